// File: rtl/io_intr_unit.sv
// Memory-mapped I/O memory: big-endian byte array accessed as 32-bit words, plus a
// 16-byte control window holding a countdown timer that drives the intr/inta handshake.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | timer stopped, intr low
// COUNT        | cnt counting down toward zero
// REQ          | interrupt pending, intr high until inta or STATUS W1C
// WAIT_ACK_LOW | request retired, waiting for inta to drop before rearming
module io_intr_unit #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] CTRL_BASE = 12'hFF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       D_In,
    output logic [31:0]       D_Out,
    input  logic              inta,
    output logic              intr
);

    localparam int         DEPTH      = 2 ** ADDR_W;
    localparam logic [1:0] OFF_RELOAD = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REQ,
        WAIT_ACK_LOW
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic              rd_en;
    logic              wr_en;
    logic              in_win;
    logic              reg_wr;
    logic              arr_wr;
    logic              ctrl_wr;
    logic              w1c;
    logic [31:0]       arr_word;
    logic [31:0]       reg_word;
    logic [31:0]       reload;
    logic              en;
    logic              auto_rl;
    logic [31:0]       cnt;
    logic [31:0]       cnt_next;
    state_t            state;
    state_t            state_next;
    logic              unused_addr_lo;

    assign rd_en          = io_cs & io_rd;
    assign wr_en          = io_cs & io_wr;
    assign in_win         = (Address[ADDR_W-1:4] == CTRL_BASE[ADDR_W-1:4]);
    assign reg_wr         = wr_en & in_win;
    assign arr_wr         = wr_en & ~in_win;
    assign ctrl_wr        = reg_wr & (Address[3:2] == OFF_CTRL);
    assign w1c            = reg_wr & (Address[3:2] == OFF_STATUS) & D_In[0];
    assign word_idx       = Address[ADDR_W-1:2];
    assign unused_addr_lo = ^Address[1:0];

    // The window aliases the top of the array; those bytes are simply never touched.
    assign arr_word = {mem[{word_idx, 2'b00}], mem[{word_idx, 2'b01}],
                       mem[{word_idx, 2'b10}], mem[{word_idx, 2'b11}]};

    always_ff @(posedge clk) begin
        if (arr_wr) begin
            mem[{word_idx, 2'b00}] <= D_In[31:24];
            mem[{word_idx, 2'b01}] <= D_In[23:16];
            mem[{word_idx, 2'b10}] <= D_In[15:8];
            mem[{word_idx, 2'b11}] <= D_In[7:0];
        end
    end

    always_comb begin
        reg_word = 32'h0;
        case (Address[3:2])
            OFF_RELOAD: reg_word = reload;
            OFF_CTRL:   reg_word = {30'h0, auto_rl, en};
            OFF_STATUS: reg_word = {31'h0, state == REQ};
            default:    reg_word = 32'h0;
        endcase
    end

    assign D_Out = rd_en ? (in_win ? reg_word : arr_word) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload  <= 32'h0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
        end else begin
            if (reg_wr && (Address[3:2] == OFF_RELOAD)) begin
                reload <= D_In;
            end
            if (ctrl_wr) begin
                en      <= D_In[0];
                auto_rl <= D_In[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Decisions use register values from before the edge, so a CTRL write loads the old RELOAD.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (ctrl_wr && D_In[0]) begin
                    cnt_next   = reload;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (ctrl_wr && !D_In[0]) begin
                    state_next = IDLE;
                end else if (ctrl_wr) begin
                    cnt_next = reload;
                end else if (cnt == 32'd0) begin
                    state_next = REQ;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            REQ: begin
                if (inta || w1c) begin
                    state_next = WAIT_ACK_LOW;
                end
            end
            WAIT_ACK_LOW: begin
                if (!inta) begin
                    if (en && auto_rl) begin
                        cnt_next   = reload;
                        state_next = COUNT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign intr = (state == REQ);

endmodule

// File: tb/tb_io_intr_unit.sv
// Randomized and directed bench for io_intr_unit against a time-based reference model:
// the model schedules the interrupt as an absolute edge number instead of counting down.
module tb_io_intr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [11:0] Address;
    logic [31:0] D_In;
    logic [31:0] D_Out;
    logic        inta;
    logic        intr;

    always #5 clk = ~clk;

    io_intr_unit #(.ADDR_W(12), .CTRL_BASE(12'hFF0)) dut (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .Address(Address), .D_In(D_In), .D_Out(D_Out), .inta(inta), .intr(intr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0]  m_mem [4096];
    bit          m_written [1024];
    logic [31:0] m_reload;
    bit          m_en, m_auto, m_req, m_ack;
    longint      m_fire = -1;
    longint      edge_no = 0;
    logic [31:0] last_rd;

    function automatic bit m_in_win(input logic [11:0] a);
        return a[11:4] == 8'hFF;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (m_in_win(a)) begin
            case (a[3:2])
                2'd0:    return m_reload;
                2'd1:    return {30'h0, m_auto, m_en};
                2'd2:    return {31'h0, m_req};
                default: return 32'h0;
            endcase
        end
        return {m_mem[{a[11:2], 2'b00}], m_mem[{a[11:2], 2'b01}],
                m_mem[{a[11:2], 2'b10}], m_mem[{a[11:2], 2'b11}]};
    endfunction

    task automatic m_reset();
        m_reload = 32'h0; m_en = 0; m_auto = 0; m_req = 0; m_ack = 0; m_fire = -1;
    endtask

    task automatic m_edge(input bit rst, input bit cs, input bit wr, input logic [11:0] a,
                          input logic [31:0] d, input bit ia);
        bit w, win_w, ctrl_w, w1c;
        w      = cs && wr;
        win_w  = w && m_in_win(a);
        ctrl_w = win_w && (a[3:2] == 2'd1);
        w1c    = win_w && (a[3:2] == 2'd2) && d[0];
        if (rst) begin
            m_reset();
        end else begin
            if (m_req) begin
                if (ia || w1c) begin m_req = 0; m_ack = 1; end
            end else if (m_ack) begin
                if (!ia) begin
                    m_ack = 0;
                    if (m_en && m_auto) m_fire = edge_no + longint'(m_reload) + 1;
                end
            end else if (m_fire >= 0) begin
                if (ctrl_w) m_fire = d[0] ? edge_no + longint'(m_reload) + 1 : -1;
                else if (edge_no == m_fire) begin m_req = 1; m_fire = -1; end
            end else if (ctrl_w && d[0]) begin
                m_fire = edge_no + longint'(m_reload) + 1;
            end
            if (win_w && a[3:2] == 2'd0) m_reload = d;
            if (ctrl_w) begin m_en = d[0]; m_auto = d[1]; end
        end
        if (w && !m_in_win(a)) begin
            m_mem[{a[11:2], 2'b00}] = d[31:24];
            m_mem[{a[11:2], 2'b01}] = d[23:16];
            m_mem[{a[11:2], 2'b10}] = d[15:8];
            m_mem[{a[11:2], 2'b11}] = d[7:0];
            m_written[a[11:2]] = 1;
        end
    endtask

    // One bus cycle: drive at negedge, check outputs, then apply the edge to the model.
    task automatic step(input bit rst, input bit cs, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [31:0] d, input bit ia);
        @(negedge clk);
        reset = rst; io_cs = cs; io_rd = rd; io_wr = wr; Address = a; D_In = d; inta = ia;
        #1;
        check("intr", {31'h0, intr}, {31'h0, m_req});
        if (cs && rd) begin
            last_rd = D_Out;
            if (m_in_win(a) || m_written[a[11:2]]) check("rdata", D_Out, m_read(a));
        end else begin
            check("dout_idle", D_Out, 32'h0);
        end
        @(posedge clk);
        edge_no++;
        m_edge(rst, cs, wr, a, d, ia);
    endtask

    task automatic idle();                                   step(0, 0, 0, 0, 12'h0, 32'h0, 0); endtask
    task automatic wr_word(input logic [11:0] a, input logic [31:0] d); step(0, 1, 0, 1, a, d, 0); endtask
    task automatic rd_word(input logic [11:0] a);            step(0, 1, 1, 0, a, 32'h0, 0); endtask
    task automatic pulse_inta();                             step(0, 0, 0, 0, 12'h0, 32'h0, 1); endtask

    // Edges elapsed after the last step until intr is seen high, bounded by limit.
    task automatic count_to_intr(input int limit, output int n, output bit seen);
        n = 0; seen = 0;
        for (int i = 0; i <= limit; i++) begin
            #2;
            if (intr) begin seen = 1; break; end
            if (n == limit) break;
            idle();
            n++;
        end
    endtask

    int n;
    bit seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; io_cs = 0; io_rd = 0; io_wr = 0; Address = '0; D_In = '0; inta = 0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        check("reset_intr", {31'h0, intr}, 32'h0);
        rd_word(12'hFF0); check("reset_reload", last_rd, 32'h0);
        rd_word(12'hFF4); check("reset_ctrl", last_rd, 32'h0);
        rd_word(12'hFF8); check("reset_status", last_rd, 32'h0);

        // Array access
        wr_word(12'h010, 32'hDEADBEEF);
        rd_word(12'h010); check("arr_rd", last_rd, 32'hDEADBEEF);
        rd_word(12'h013); check("arr_rd_lowbits", last_rd, 32'hDEADBEEF);
        step(0, 0, 1, 0, 12'h010, 32'h0, 0);
        #1 check("arr_no_cs", D_Out, 32'h0);
        wr_word(12'h020, 32'h01020304);
        step(0, 1, 1, 1, 12'h020, 32'hCAFEF00D, 0); check("rdwr_prewrite", last_rd, 32'h01020304);
        rd_word(12'h020); check("rdwr_post", last_rd, 32'hCAFEF00D);

        // Control window isolation
        wr_word(12'hFEC, 32'hA5A55A5A);
        wr_word(12'hFF0, 32'h12345678);
        rd_word(12'hFF0); check("win_reload", last_rd, 32'h12345678);
        rd_word(12'hFFC); check("win_reserved", last_rd, 32'h0);
        rd_word(12'hFEC); check("win_alias_arr", last_rd, 32'hA5A55A5A);

        // Single-shot
        wr_word(12'hFF0, 32'd3);
        wr_word(12'hFF4, 32'd1);
        count_to_intr(50, n, seen);
        check("single_seen", {31'h0, seen}, 32'h1);
        check("single_latency", n, 32'd4);
        rd_word(12'hFF8); check("single_status", last_rd, 32'h1);
        pulse_inta();
        #2 check("single_ack_intr", {31'h0, intr}, 32'h0);
        rd_word(12'hFF8); check("single_status_clr", last_rd, 32'h0);
        count_to_intr(20, n, seen);
        check("single_quiet", {31'h0, seen}, 32'h0);

        // Auto-reload
        wr_word(12'hFF0, 32'd0);
        wr_word(12'hFF4, 32'd3);
        count_to_intr(50, n, seen);
        check("auto_first", n, 32'd1);
        for (int k = 0; k < 3; k++) begin
            pulse_inta();
            idle();
            count_to_intr(50, n, seen);
            check("auto_seen", {31'h0, seen}, 32'h1);
            check("auto_latency", n, 32'd1);
        end

        // Disable in REQ, then W1C
        wr_word(12'hFF4, 32'd0);
        #2 check("disable_keeps_intr", {31'h0, intr}, 32'h1);
        wr_word(12'hFF8, 32'd1);
        #2 check("w1c_intr", {31'h0, intr}, 32'h0);
        count_to_intr(20, n, seen);
        check("w1c_quiet", {31'h0, seen}, 32'h0);

        // Reset mid-count
        wr_word(12'hFF0, 32'd10);
        wr_word(12'hFF4, 32'd1);
        repeat (5) idle();
        step(1, 0, 0, 0, 12'h0, 32'h0, 0);
        #2 check("rst_intr", {31'h0, intr}, 32'h0);
        rd_word(12'hFF0); check("rst_reload", last_rd, 32'h0);
        rd_word(12'hFF4); check("rst_ctrl", last_rd, 32'h0);
        rd_word(12'h010); check("rst_keeps_arr", last_rd, 32'hDEADBEEF);
        count_to_intr(20, n, seen);
        check("rst_quiet", {31'h0, seen}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit ia;
            logic [11:0] a_pool, a_win;
            r      = $urandom_range(0, 99);
            ia     = ($urandom_range(0, 3) == 0);
            a_pool = 12'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            a_win  = 12'hFF0 | 12'($urandom_range(0, 15));
            if (r < 15)      step(0, 1, 0, 1, 12'hFF0, 32'($urandom_range(0, 6)), ia);
            else if (r < 25) step(0, 1, 0, 1, 12'hFF4, 32'($urandom_range(0, 3)), ia);
            else if (r < 32) step(0, 1, 0, 1, 12'hFF8, 32'($urandom_range(0, 1)), ia);
            else if (r < 45) step(0, 1, 1, 0, a_win, 32'h0, ia);
            else if (r < 58) step(0, 1, 0, 1, a_pool, $urandom, ia);
            else if (r < 72) step(0, 1, 1, 0, a_pool, 32'h0, ia);
            else if (r < 77) step(0, 1, 1, 1, a_pool, $urandom, ia);
            else if (r < 79) step(1, 0, 0, 0, 12'h0, 32'h0, 0);
            else if (r < 84) step(0, 0, 1'($urandom), 1'($urandom), a_win, 32'h1, ia);
            else             step(0, 0, 0, 0, 12'h0, 32'h0, ia);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_intr_unit.md
Name: io_intr_unit

Overview:
- Memory-mapped I/O memory that sits directly downstream of the CPU's I/O bus.
- Consumes io_cs/io_rd/io_wr, the low address bits of the ALU output, and the D_OUT store data.
- Returns read data to the CPU's memory-read mux.
- Contains a programmable countdown timer that raises intr to the MCU and retires it on the inta handshake, so the CPU's interrupt path can be exercised.

Parameters:
- ADDR_W, 12: byte-address width; the array holds 2**ADDR_W bytes.
- CTRL_BASE, 12'hFF0: byte address of the control window. The window is 16 bytes and aliases the top of the array.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_cs  in  1  chip select.
- io_rd  in  1  read strobe (qualified by io_cs).
- io_wr  in  1  write strobe (qualified by io_cs).
- Address  in  ADDR_W  byte address. Address[1:0] is ignored; all accesses are 32-bit words.
- D_In  in  32  write data from CPU D_OUT.
- D_Out  out  32  read data to CPU.
- inta  in  1  interrupt acknowledge from MCU.
- intr  out  1  interrupt request to MCU.

Behaviour:
- Memory organisation:
  - Byte array, big-endian. A word at aligned address A occupies bytes A (bits 31:24), A+1, A+2 and A+3 (bits 7:0).
  - Array contents are not cleared by reset.
- Read path (combinational, zero latency):
  - D_Out = selected word when io_cs & io_rd, else 32'h0.
- Write path:
  - On the clock edge where io_cs & io_wr, D_In is written.
  - io_rd and io_wr together: the write commits at the edge; D_Out shows the pre-write value during that cycle.
- Control window: Address[ADDR_W-1:4] == CTRL_BASE[ADDR_W-1:4]. Accesses in the window go to registers, never to the array.
  - +0 RELOAD: 32-bit read/write; timer reload value.
  - +4 CTRL: bit0 EN, bit1 AUTO; bits 31:2 read 0 and ignore writes.
  - +8 STATUS: bit0 PEND, read-only from FSM. Writing 1 to bit0 clears the pending request (W1C). Other bits read 0.
  - +C reserved: reads 0, writes ignored.
- Reset:
  - RELOAD = 0, CTRL = 0, cnt = 0, state IDLE, intr = 0.
  - D_Out follows the read rule (0 while no read is active).
  - Reset in any state aborts immediately. intr is low the cycle after the reset edge.
- Timer FSM, with a 32-bit down-counter cnt:
  - IDLE: intr = 0. A CTRL write with EN=1 loads cnt = RELOAD (using the value of RELOAD before that edge's write) and moves to COUNT.
  - COUNT:
    - If EN is cleared by a write, go to IDLE.
    - Else if cnt == 0, go to REQ.
    - Else cnt decrements by 1.
    - intr rises exactly RELOAD+1 cycles after the enabling write edge. RELOAD = 0 gives intr one cycle after.
  - REQ: intr = 1, PEND = 1. Clearing EN does not drop intr; the request stays until acknowledged or cleared.
    - inta sampled high, or STATUS W1C: intr = 0 on the next cycle and the FSM moves to WAIT_ACK_LOW.
  - WAIT_ACK_LOW: intr = 0, PEND = 0. Waits for inta = 0, then:
    - if EN & AUTO: cnt = RELOAD and go to COUNT;
    - otherwise go to IDLE.
    - A W1C clear with inta already low makes this state last exactly one cycle.
- Simultaneous events:
  - inta outside REQ is ignored.
  - CTRL write with EN=1 while in COUNT restarts the countdown (cnt = RELOAD).
  - RELOAD write during COUNT affects only the next reload, not the running cnt.
  - inta and W1C in the same cycle are treated as one acknowledge.
- cnt does not wrap: it is never decremented below 0.

Test Plan:
- Array read/write: after reset, write 32'hDEADBEEF to 12'h010, then read 12'h010 → 32'hDEADBEEF. Read 12'h013 (low bits ignored) → 32'hDEADBEEF. With io_cs=0, D_Out = 0.
- Single-shot timer: write RELOAD = 3, then CTRL = 1. intr rises 4 cycles after the CTRL write edge and STATUS reads 1. Pulse inta for one cycle: intr = 0 the next cycle, STATUS reads 0, the FSM returns to IDLE, and intr stays low for the next 20 cycles.
- Auto-reload: RELOAD = 0, CTRL = 3. intr rises 1 cycle after the write. Each inta pulse (inta high 1 cycle, low 1 cycle) yields intr again 1 cycle after the FSM re-enters COUNT. Check 3 consecutive interrupts.
- W1C and disable:
  - In REQ, clear EN: intr stays 1.
  - Write STATUS = 1: intr = 0 the next cycle, FSM goes to IDLE, no further interrupts.
- Reset mid-operation: RELOAD = 10, EN = 1, assert reset after 5 cycles. The cycle after the reset edge: intr = 0, RELOAD and CTRL read 0. The word previously written at 12'h010 still reads 32'hDEADBEEF.
- Control window isolation: write 32'h12345678 to 12'hFF0, then read 12'hFF0 → 32'h12345678 (RELOAD). Read 12'hFFC → 0. Read 12'hFEC → unaffected array value.
